mult_seq_ctrl: RTL

- Sequential shift-and-add controller that multiplies two WIDTH-bit unsigned operands using one shared, external, purely combinational 2*WIDTH-bit adder (the team's eight-bit full adder at the default WIDTH=4).
- Provides a low-area alternative to the 4x4 array multiplier: one adder reused over WIDTH cycles instead of a partial-product array.
- The block owns the operand registers, the accumulator, the iteration counter and the start/done handshake.
- The adder sits outside the block. The block drives the adder inputs and samples its sum in the same cycle.

---
 rtl/mult_seq_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequential shift-and-add unsigned multiplier controller.
// The block owns the operand registers, the accumulator, the iteration
// counter and the start/done handshake. The PW-bit adder lives outside the
// block. This block drives add_a/add_b/add_cin and samples add_sum/add_cout
// in the same cycle.
//
// Handshake: a request is accepted at a rising edge where start=1 and
// ready=1 (IDLE only). start is ignored while busy. The result is valid on
// Product for the single cycle where done=1, and it holds afterwards until the
// next operation reaches DONE. There is no back-pressure on done.

module mult_seq_ctrl #(
   parameter  int WIDTH = 4,
   localparam int PW    = 2 * WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [PW-1:0]    Product,
   output logic             err,
   output logic [PW-1:0]    add_a,
   output logic [PW-1:0]    add_b,
   output logic             add_cin,
   input  logic [PW-1:0]    add_sum,
   input  logic             add_cout,
   output logic [1:0]       dbg_state_o
);

   // Counter holds 0..WIDTH-1 during RUN. The extra bit keeps cnt+1 from
   // wrapping at the last RUN cycle.
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mplr_q,  mplr_d;
   logic [PW-1:0]    acc_q,   acc_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [PW-1:0]    prod_q,  prod_d;
   logic             err_q,   err_d;

   // Accumulator value after this cycle's conditional add. It also feeds
   // Product on the last RUN cycle, so the final add is included.
   logic [PW-1:0]    acc_next;

   // State and datapath registers, with synchronous reset taking priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         mcand_q <= '0;
         mplr_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic, datapath updates and adder operand drive.
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplr_d   = mplr_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      err_d    = err_q;
      acc_next = acc_q;
      add_a    = '0;
      add_b    = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mcand_d = {{WIDTH{1'b0}}, A};
               mplr_d  = B;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            // The adder is only looked at when the multiplier bit is set.
            // Its carry flags err only on those cycles.
            add_a = acc_q;
            add_b = mcand_q;
            if (mplr_q[0]) begin
               acc_next = add_sum;
               if (add_cout) begin
                  err_d = 1'b1;
               end
            end
            acc_d   = acc_next;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            // A fixed WIDTH iterations run. There is no early exit when mplr empties.
            if (cnt_q == CNT_LAST) begin
               prod_d  = acc_next;
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Status outputs decode from registered state only.
   assign ready       = (state_q == S_IDLE);
   assign busy        = (state_q == S_RUN) || (state_q == S_DONE);
   assign done        = (state_q == S_DONE);
   assign Product     = prod_q;
   assign err         = err_q;
   assign add_cin     = 1'b0;
   assign dbg_state_o = state_q;

endmodule
